// File: rtl/rr_ppe_ctrl.sv
// Round-robin grant controller around an external programmable priority encoder.
// Optional grant counter enabled by defining RR_PPE_GNT_CNT_EN.
module rr_ppe_ctrl (
  input  logic          clk,
  input  logic          rst,
  input  logic [1023:0] req_set,
  output logic [1023:0] Req,
  output logic [9:0]    P_enc,
  input  logic [9:0]    o_value,
  input  logic          valid,
  output logic [9:0]    gnt_idx,
  output logic          gnt_vld,
  input  logic          gnt_rdy,
  output logic [15:0]   gnt_cnt
);

  localparam int unsigned N = 1024;
  localparam int unsigned W = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d, clr;
  logic [W-1:0]   ptr_q, idx_q;
  logic           vld_q;
  logic           capture, accept;

  // Next-state and handshake strobes.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    capture = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        // An all-zero pending vector makes the encoder output meaningless.
        if (valid && (|pending_q)) begin
          capture = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (vld_q && gnt_rdy) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr          = '0;
    clr[o_value] = capture;
    // Set wins over clear on the same bit.
    pending_d    = (pending_q & ~clr) | req_set;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the pending flop array is reset explicitly because Req feeds the encoder straight after reset.
    if (rst) begin
      pending_q <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      vld_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (capture) begin
        idx_q <= o_value;
        vld_q <= 1'b1;
      end else if (accept) begin
        ptr_q <= idx_q + W'(1);
        vld_q <= 1'b0;
      end
    end
  end

  assign Req     = pending_q;
  assign P_enc   = ptr_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;

`ifdef RR_PPE_GNT_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign gnt_cnt = cnt_q;
`else
  assign gnt_cnt = '0;
`endif

  // The offer flag and the FSM state must always agree.
  a_vld_state : assert property (@(posedge clk) disable iff (rst)
    gnt_vld == (state_q == OFFER));

endmodule

// File: tb/tb_rr_ppe_ctrl.sv
// Directed bench for rr_ppe_ctrl; includes a behavioural model of the
// programmable priority encoder that closes the loop around the DUT.
module tb_rr_ppe_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic [1023:0] req_set;
  logic [1023:0] Req;
  logic [9:0]    P_enc;
  logic [9:0]    o_value;
  logic          valid;
  logic [9:0]    gnt_idx;
  logic          gnt_vld;
  logic          gnt_rdy;
  logic [15:0]   gnt_cnt;

  logic          force_valid;
  logic          enc_valid;
  logic [9:0]    enc_value;
  logic [9:0]    enc_j;

  int n_pass  = 0;
  int n_total = 0;

`ifdef RR_PPE_GNT_CNT_EN
  localparam logic [15:0] CNT_AFTER3 = 16'd3;
`else
  localparam logic [15:0] CNT_AFTER3 = 16'd0;
`endif

  always #5 clk = ~clk;

  rr_ppe_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .req_set (req_set),
    .Req     (Req),
    .P_enc   (P_enc),
    .o_value (o_value),
    .valid   (valid),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .gnt_rdy (gnt_rdy),
    .gnt_cnt (gnt_cnt)
  );

  // Encoder model: first set bit at or after P_enc, wrapping at 1024.
  always_comb begin
    enc_valid = 1'b0;
    enc_value = '0;
    enc_j     = '0;
    for (int k = 1023; k >= 0; k--) begin
      enc_j = P_enc + 10'(k);
      if (Req[enc_j]) begin
        enc_valid = 1'b1;
        enc_value = enc_j;
      end
    end
  end

  assign valid   = enc_valid | force_valid;
  assign o_value = enc_value;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_req(input string tag, input logic [1023:0] exp);
    for (int q = 0; q < 4; q++)
      check($sformatf("%s[%0d]", tag, q), Req[q*256 +: 256], exp[q*256 +: 256]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse(input int b);
    req_set    = '0;
    req_set[b] = 1'b1;
    tick();
    req_set    = '0;
  endtask

  task automatic wait_grant(input string tag, input logic [9:0] exp);
    int n = 0;
    while (!gnt_vld && n < 20) begin
      tick();
      n++;
    end
    check({tag, " vld"}, 256'(gnt_vld), 256'(1));
    check({tag, " idx"}, 256'(gnt_idx), 256'(exp));
  endtask

  task automatic accept_grant();
    gnt_rdy = 1'b1;
    tick();
    gnt_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1023:0] exp_req;
    rst         = 1'b1;
    req_set     = '0;
    gnt_rdy     = 1'b0;
    force_valid = 1'b0;

    // Reset overrides req_set and gnt_rdy.
    req_set[9] = 1'b1;
    gnt_rdy    = 1'b1;
    tick();
    tick();
    req_set = '0;
    gnt_rdy = 1'b0;
    rst     = 1'b0;
    check_req("rst req", '0);
    check("rst penc", 256'(P_enc), 256'(0));
    check("rst idx", 256'(gnt_idx), 256'(0));
    check("rst vld", 256'(gnt_vld), 256'(0));
    check("rst cnt", 256'(gnt_cnt), 256'(0));

    // gnt_rdy without an offer, and valid with nothing pending: no effect.
    gnt_rdy     = 1'b1;
    force_valid = 1'b1;
    repeat (3) tick();
    gnt_rdy     = 1'b0;
    force_valid = 1'b0;
    check("idle vld", 256'(gnt_vld), 256'(0));
    check("idle penc", 256'(P_enc), 256'(0));
    check("idle idx", 256'(gnt_idx), 256'(0));

    // Single request, latency of two edges.
    pulse(5);
    exp_req    = '0;
    exp_req[5] = 1'b1;
    check_req("single req", exp_req);
    check("single vld0", 256'(gnt_vld), 256'(0));
    tick();
    check("single vld1", 256'(gnt_vld), 256'(1));
    check("single idx", 256'(gnt_idx), 256'(5));
    check_req("single clr", '0);
    accept_grant();
    check("single penc", 256'(P_enc), 256'(6));
    check("single done", 256'(gnt_vld), 256'(0));

    // Round-robin order with gnt_rdy held high.
    do_reset();
    req_set       = '0;
    req_set[3]    = 1'b1;
    req_set[700]  = 1'b1;
    req_set[1000] = 1'b1;
    gnt_rdy       = 1'b1;
    tick();
    req_set = '0;
    wait_grant("rr 3", 10'd3);
    tick();
    check("rr gap vld", 256'(gnt_vld), 256'(0));
    check("rr penc4", 256'(P_enc), 256'(4));
    wait_grant("rr 700", 10'd700);
    tick();
    check("rr penc701", 256'(P_enc), 256'(701));
    wait_grant("rr 1000", 10'd1000);
    tick();
    check("rr penc1001", 256'(P_enc), 256'(1001));
    pulse(3);
    wait_grant("rr 3 again", 10'd3);
    tick();
    check("rr penc4b", 256'(P_enc), 256'(4));
    gnt_rdy = 1'b0;

    // Wrap-around of the start pointer.
    do_reset();
    pulse(1023);
    wait_grant("wrap 1023", 10'd1023);
    accept_grant();
    check("wrap penc0", 256'(P_enc), 256'(0));
    pulse(1022);
    wait_grant("wrap 1022", 10'd1022);
    accept_grant();
    check("wrap penc1023", 256'(P_enc), 256'(1023));
    req_set       = '0;
    req_set[0]    = 1'b1;
    req_set[1023] = 1'b1;
    tick();
    req_set = '0;
    wait_grant("wrap first", 10'd1023);
    accept_grant();
    check("wrap penc0b", 256'(P_enc), 256'(0));
    wait_grant("wrap second", 10'd0);
    accept_grant();
    check("wrap penc1", 256'(P_enc), 256'(1));

    // Backpressure: offer holds while new requests accumulate.
    pulse(50);
    wait_grant("bp 50", 10'd50);
    exp_req = '0;
    for (int i = 0; i < 10; i++) begin
      req_set            = '0;
      req_set[100 + i]   = 1'b1;
      tick();
      exp_req[100 + i]   = 1'b1;
      check($sformatf("bp idx %0d", i), 256'(gnt_idx), 256'(50));
      check($sformatf("bp vld %0d", i), 256'(gnt_vld), 256'(1));
    end
    req_set = '0;
    check("bp penc held", 256'(P_enc), 256'(1));
    check_req("bp req", exp_req);
    accept_grant();
    check("bp penc51", 256'(P_enc), 256'(51));
    check("bp vld off", 256'(gnt_vld), 256'(0));
    wait_grant("bp next", 10'd100);

    // Set in the same cycle as the clear: bit survives, second grant follows.
    do_reset();
    req_set    = '0;
    req_set[7] = 1'b1;
    tick();
    tick();
    req_set = '0;
    check("sc vld", 256'(gnt_vld), 256'(1));
    check("sc idx", 256'(gnt_idx), 256'(7));
    exp_req    = '0;
    exp_req[7] = 1'b1;
    check_req("sc req", exp_req);
    accept_grant();
    check("sc penc8", 256'(P_enc), 256'(8));
    wait_grant("sc again", 10'd7);
    check_req("sc empty", '0);

    // Reset in the middle of an offer.
    do_reset();
    pulse(10);
    wait_grant("mid 10", 10'd10);
    accept_grant();
    pulse(20);
    wait_grant("mid 20", 10'd20);
    accept_grant();
    pulse(30);
    wait_grant("mid 30", 10'd30);
    accept_grant();
    check("mid cnt3", 256'(gnt_cnt), 256'(CNT_AFTER3));
    pulse(40);
    wait_grant("mid 40", 10'd40);
    pulse(41);
    rst         = 1'b1;
    req_set[42] = 1'b1;
    gnt_rdy     = 1'b1;
    tick();
    rst     = 1'b0;
    req_set = '0;
    gnt_rdy = 1'b0;
    check("mid vld", 256'(gnt_vld), 256'(0));
    check("mid penc", 256'(P_enc), 256'(0));
    check("mid cnt", 256'(gnt_cnt), 256'(0));
    check("mid idx", 256'(gnt_idx), 256'(0));
    check_req("mid req", '0);
    tick();
    check("mid after", 256'(gnt_vld), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
